mem_initiator: RTL

Bus initiator for the native valid/ready memory interface used by the SoC peripherals (mem_valid/mem_addr/mem_wdata/mem_wstrb out; mem_ready/mem_rdata in).
Accepts single- or multi-beat read/write commands on a simple cmd channel and issues one bus transaction per beat. Returns one response per beat on a backpressurable rsp channel.
Used by test harnesses and debug/loader logic to drive peripherals (GPIO, UART, RAM) without the CPU. Includes a per-beat timeout so that an unmapped address cannot hang the initiator.

---
 rtl/mem_bus_pkg.sv | 16 +
 rtl/mem_timeout_ctr.sv | 31 +++
 rtl/mem_initiator.sv | 134 +++++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and widths for native valid/ready memory bus masters.
package mem_bus_pkg;
    localparam int MEM_AW = 32;
    localparam int MEM_DW = 32;
    localparam int MEM_SW = 4;
    localparam int LEN_W  = 8;
    localparam int TMR_W  = 16;

    localparam int unsigned DEF_ADDR_INC = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RSP  = 2'd2
    } state_e;
endpackage

// File: rtl/mem_timeout_ctr.sv
// Clear/enable up-counter with a terminal-count flag, used as a per-beat bus timeout.
module mem_timeout_ctr #(
    parameter int          W        = 16,
    parameter int unsigned TERMINAL = 254
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);
    logic [W-1:0] cnt_q, cnt_d;

    // Clear has priority so a new beat always starts counting from zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i && !tc_o)
            cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk) begin
        if (!resetn)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign tc_o = (cnt_q == W'(TERMINAL));
endmodule

// File: rtl/mem_initiator.sv
// Command-driven initiator: one bus transaction and one response per beat, with per-beat timeout.
module mem_initiator
    import mem_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned ADDR_INC       = DEF_ADDR_INC
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [MEM_AW-1:0] cmd_addr,
    input  logic [MEM_DW-1:0] cmd_wdata,
    input  logic [MEM_SW-1:0] cmd_wstrb,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [MEM_DW-1:0] rsp_rdata,
    output logic              rsp_last,
    output logic              rsp_err,
    output logic              mem_valid,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [MEM_DW-1:0] mem_wdata,
    output logic [MEM_SW-1:0] mem_wstrb,
    input  logic              mem_ready,
    input  logic [MEM_DW-1:0] mem_rdata
);
    state_e            state_q, state_d;
    logic              write_q, write_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic [MEM_DW-1:0] wdata_q, wdata_d;
    logic [MEM_SW-1:0] wstrb_q, wstrb_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [MEM_DW-1:0] rdata_q, rdata_d;
    logic              last_q, last_d;
    logic              err_q, err_d;
    logic              tmr_tc;

    mem_timeout_ctr #(
        .W        (TMR_W),
        .TERMINAL (TIMEOUT_CYCLES - 1)
    ) u_tmr (
        .clk    (clk),
        .resetn (resetn),
        .clr_i  (state_q != BUS),
        .en_i   (!mem_ready),
        .tc_o   (tmr_tc)
    );

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        len_d   = len_q;
        rdata_d = rdata_q;
        last_d  = last_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    write_d = cmd_write;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    // Strobes are forced to zero on reads so responders never see a write.
                    wstrb_d = cmd_write ? cmd_wstrb : '0;
                    len_d   = cmd_len;
                    state_d = BUS;
                end
            end
            BUS: begin
                if (mem_ready) begin
                    rdata_d = write_q ? '0 : mem_rdata;
                    err_d   = 1'b0;
                    last_d  = (len_q == '0);
                    state_d = RSP;
                end else if (tmr_tc) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    last_d  = 1'b1;
                    state_d = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    if (last_q) begin
                        state_d = IDLE;
                    end else begin
                        addr_d  = addr_q + MEM_AW'(ADDR_INC);
                        len_d   = len_q - LEN_W'(1);
                        state_d = BUS;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            len_q   <= '0;
            rdata_q <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            len_q   <= len_d;
            rdata_q <= rdata_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    assign cmd_ready = (state_q == IDLE) && resetn;
    assign mem_valid = (state_q == BUS);
    assign rsp_valid = (state_q == RSP);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wstrb = wstrb_q;
    assign rsp_rdata = rdata_q;
    assign rsp_last  = last_q;
    assign rsp_err   = err_q;
endmodule
